uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer directly downstream of the UART receiver. Captures each byte the receiver presents on its single-cycle `data_valid` pulse into a circular buffer and offers the bytes to the host side through a valid/ready read port. It decouples frame arrival from host consumption and reports fill level, full/empty status and a sticky overflow flag when a byte arrives with no free slot.

## Interface

Parameters:
- `DATA_WIDTH`, 8: width of the received word; must match the receiver's `P_DATA`.
- `DEPTH`, 8: number of entries; power of two, ≥ 2.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: derived; not to be overridden.

Ports:
- `CLK`, input, 1: single clock, rising edge. All state is in this domain.
- `RST`, input, 1: synchronous, active-high reset.
- `P_DATA`, input, `DATA_WIDTH`: parallel byte from the receiver.
- `data_valid`, input, 1: one-cycle write strobe from the receiver; `P_DATA` is valid in the same cycle.
- `RD_DATA`, output, `DATA_WIDTH`: oldest stored byte (show-ahead); 0 when empty.
- `RD_VALID`, output, 1: high when `RD_DATA` holds a valid byte (`!EMPTY`).
- `RD_READY`, input, 1: consumer accepts `RD_DATA` this cycle.
- `COUNT`, output, `ADDR_WIDTH+1`: number of stored entries, 0..`DEPTH`.
- `FULL`, output, 1: `COUNT == DEPTH`.
- `EMPTY`, output, 1: `COUNT == 0`.
- `OVERFLOW`, output, 1: sticky; a byte was dropped.
- `OVF_CLR`, input, 1: clears `OVERFLOW`.

## Operation

- Storage: `DEPTH` × `DATA_WIDTH` register array. The array is not reset.
- Pointers: `wr_ptr` and `rd_ptr`, each `ADDR_WIDTH+1` bits. The low `ADDR_WIDTH` bits index the array and the MSB is the wrap bit; pointers wrap naturally modulo 2·`DEPTH`.
- `COUNT` = `wr_ptr − rd_ptr` (modulo 2^(`ADDR_WIDTH`+1)), registered or derived combinationally from registered pointers.
- Pop condition: `pop = RD_VALID && RD_READY`. On pop, `rd_ptr` increments.
- Push condition: `push = data_valid && (!FULL || pop)`. On push, `mem[wr_ptr] <= P_DATA` and `wr_ptr` increments.
- Simultaneous push and pop:
  - Both take effect; `COUNT` is unchanged.
  - When full, this is legal and no byte is dropped.
  - When empty, no pop can occur (`RD_VALID` = 0), so only the push happens.
- Drop condition: `data_valid && FULL && !pop`. The byte is discarded; pointers and memory are unchanged, and `OVERFLOW` is set.
- `OVERFLOW` priority: set takes priority over `OVF_CLR` in the same cycle. Otherwise `OVF_CLR` clears it.
- `RD_DATA` = `mem[rd_ptr[ADDR_WIDTH-1:0]]` when `!EMPTY`, else all-zero.
- `RD_READY` while empty is ignored.
- No state machine beyond pointer/flag registers. Behaviour is fully determined by `push`/`pop`/drop each cycle.

## Timing

- Reset: while `RST` is high at a rising edge, the block clears `wr_ptr`, `rd_ptr` and `OVERFLOW`. This holds regardless of other inputs, including a `data_valid` in the same cycle (that byte is lost and does not set `OVERFLOW`).
- Reset values: `COUNT` = 0, `EMPTY` = 1, `FULL` = 0, `RD_VALID` = 0, `RD_DATA` = 0, `OVERFLOW` = 0.
- Reset mid-operation discards all contents.
- Write-to-read latency: a byte pushed at edge N is visible on `RD_DATA` with `RD_VALID` = 1 after edge N (one cycle). There is no combinational path from `data_valid`/`P_DATA` to `RD_*`.
- Pop timing: on a pop at edge N, the next byte (or `EMPTY`) appears after edge N.
- Flag timing: `FULL`, `EMPTY`, `COUNT` and `OVERFLOW` update on the same edge as the pointer change that causes them.
- Sustained throughput: one push and one pop per cycle, back-to-back. `data_valid` may be high on consecutive cycles and every pulse is one write.
- Combinational paths: the only one to an output is `RD_READY` → nothing. `pop` affects next-cycle state only; push acceptance when full depends on same-cycle `RD_READY`.

## Test plan

- **Reset check:** assert `RST` 2 cycles, then release → `EMPTY`=1, `FULL`=0, `COUNT`=0, `RD_VALID`=0, `RD_DATA`=0x00, `OVERFLOW`=0.
- **Single byte:** push 0xA5 with `RD_READY`=0 → next cycle `RD_VALID`=1, `RD_DATA`=0xA5, `COUNT`=1. Assert `RD_READY` 1 cycle → `EMPTY`=1, `COUNT`=0.
- **Fill and wrap:** push 0x01..0x08 (`DEPTH`=8) → `FULL`=1, `COUNT`=8. Pop 3 and push 0x09..0x0B → bytes read out in order 0x04..0x0B, with pointers wrapped and `OVERFLOW`=0.
- **Overflow:** when full, push 0xEE with `RD_READY`=0 → 0xEE dropped, `OVERFLOW`=1, `COUNT`=8.
- **Overflow set vs clear:** assert `OVF_CLR` and a drop in the same cycle → `OVERFLOW` stays 1. Then `OVF_CLR` alone → 0.
- **Concurrent push/pop and reset:**
  - Full plus `data_valid`=1 plus `RD_READY`=1 → byte accepted, `COUNT` stays 8, no overflow.
  - Continuous push+pop for 20 cycles → `COUNT` constant, data order preserved.
  - `RST` while `COUNT`=5 → all reset values next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer between the UART receiver and the host.
// Circular buffer with show-ahead valid/ready read port and sticky overflow flag.
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  data_valid,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  RD_VALID,
   input  logic                  RD_READY,
   output logic [ADDR_WIDTH:0]   COUNT,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  OVERFLOW,
   input  logic                  OVF_CLR
);

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  push;
   logic                  pop;
   logic                  drop;

   // Extra wrap bit on each pointer lets full and empty be told apart.
   assign COUNT    = wr_ptr - rd_ptr;
   assign EMPTY    = (wr_ptr == rd_ptr);
   assign FULL     = (COUNT == FULL_COUNT);
   assign RD_VALID = !EMPTY;
   assign RD_DATA  = EMPTY ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];

   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign pop  = RD_VALID && RD_READY;
   assign push = data_valid && (!FULL || pop);
   assign drop = data_valid && FULL && !pop;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= P_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop) begin
            OVERFLOW <= 1'b1;
         end else if (OVF_CLR) begin
            OVERFLOW <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 8;
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                  CLK;
   logic                  RST;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic [DATA_WIDTH-1:0] RD_DATA;
   logic                  RD_VALID;
   logic                  RD_READY;
   logic [ADDR_WIDTH:0]   COUNT;
   logic                  FULL;
   logic                  EMPTY;
   logic                  OVERFLOW;
   logic                  OVF_CLR;

   uart_rx_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid),
      .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
      .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
      .OVERFLOW(OVERFLOW), .OVF_CLR(OVF_CLR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of stored bytes and a sticky flag.
   logic [DATA_WIDTH-1:0] q[$];
   bit                    m_ovf = 1'b0;

   always @(posedge CLK) begin
      bit m_pop;
      bit m_full;
      bit m_drop;
      if (RST) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         m_pop  = (q.size() > 0) && RD_READY;
         m_full = (q.size() == DEPTH);
         m_drop = data_valid && m_full && !m_pop;
         if (m_pop) void'(q.pop_front());
         if (data_valid && !m_drop) q.push_back(P_DATA);
         if (m_drop) m_ovf = 1'b1;
         else if (OVF_CLR) m_ovf = 1'b0;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("model_count",    32'(COUNT),    32'(q.size()));
         chk("model_full",     32'(FULL),     32'(q.size() == DEPTH));
         chk("model_empty",    32'(EMPTY),    32'(q.size() == 0));
         chk("model_rd_valid", 32'(RD_VALID), 32'(q.size() != 0));
         chk("model_rd_data",  32'(RD_DATA),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
         chk("model_overflow", 32'(OVERFLOW), 32'(m_ovf));
      end
   end

   task automatic step(input bit dv, input logic [7:0] d, input bit rdy, input bit clr);
      data_valid = dv;
      P_DATA     = d;
      RD_READY   = rdy;
      OVF_CLR    = clr;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_empty"},    32'(EMPTY),    32'd1);
      chk({tag, "_full"},     32'(FULL),     32'd0);
      chk({tag, "_count"},    32'(COUNT),    32'd0);
      chk({tag, "_rd_valid"}, 32'(RD_VALID), 32'd0);
      chk({tag, "_rd_data"},  32'(RD_DATA),  32'h00);
      chk({tag, "_overflow"}, 32'(OVERFLOW), 32'd0);
   endtask

   initial begin
      int th_rdy;
      RST = 1'b1;
      data_valid = 1'b0;
      P_DATA = '0;
      RD_READY = 1'b0;
      OVF_CLR = 1'b0;

      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      RST = 1'b0;
      chk_reset_state("reset");
      chk_en = 1'b1;

      step(1, 8'hA5, 0, 0);
      chk("single_valid", 32'(RD_VALID), 32'd1);
      chk("single_data",  32'(RD_DATA),  32'hA5);
      chk("single_count", 32'(COUNT),    32'd1);
      step(0, 8'h00, 1, 0);
      chk("single_pop_empty", 32'(EMPTY), 32'd1);
      chk("single_pop_count", 32'(COUNT), 32'd0);

      for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
      chk("fill_full",  32'(FULL),  32'd1);
      chk("fill_count", 32'(COUNT), 32'd8);
      for (int k = 0; k < 3; k++) step(1, 8'(9 + k), 1, 0);
      chk("wrap_count", 32'(COUNT), 32'd8);
      for (int k = 0; k < 8; k++) begin
         chk("wrap_order", 32'(RD_DATA), 32'(4 + k));
         step(0, 8'h00, 1, 0);
      end
      chk("wrap_overflow", 32'(OVERFLOW), 32'd0);
      chk("wrap_drained",  32'(EMPTY),    32'd1);

      for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0);
      step(1, 8'hEE, 0, 0);
      chk("ovf_set",   32'(OVERFLOW), 32'd1);
      chk("ovf_count", 32'(COUNT),    32'd8);
      chk("ovf_head",  32'(RD_DATA),  32'h10);
      step(1, 8'hEF, 0, 1);
      chk("ovf_set_beats_clr", 32'(OVERFLOW), 32'd1);
      step(0, 8'h00, 0, 1);
      chk("ovf_clr", 32'(OVERFLOW), 32'd0);

      step(1, 8'h55, 1, 0);
      chk("full_pushpop_count", 32'(COUNT),    32'd8);
      chk("full_pushpop_ovf",   32'(OVERFLOW), 32'd0);
      chk("full_pushpop_head",  32'(RD_DATA),  32'h11);
      for (int k = 0; k < 20; k++) begin
         step(1, 8'($urandom), 1, 0);
         chk("stream_count", 32'(COUNT), 32'd8);
      end

      for (int k = 0; k < 3; k++) step(0, 8'h00, 1, 0);
      chk("pre_reset_count", 32'(COUNT), 32'd5);
      RST = 1'b1;
      step(1, 8'h77, 1, 0);
      RST = 1'b0;
      chk_reset_state("midreset");

      for (int p = 0; p < 3; p++) begin
         th_rdy = (p == 0) ? 20 : (p == 1) ? 50 : 85;
         for (int c = 0; c < 800; c++) begin
            RST = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 99) < 60, 8'($urandom),
                 $urandom_range(0, 99) < th_rdy, $urandom_range(0, 99) < 5);
         end
      end
      RST = 1'b0;
      step(0, 8'h00, 0, 0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
